// File: rtl/matmul_compute_ctrl.sv
// Compute-phase sequencer for C = A*B: walks every C[i][j], drives A/B read addresses,
// strobes the external MAC and hands each finished dot product out on ready/valid.
module matmul_compute_ctrl #(
  parameter int unsigned M           = 7,
  parameter int unsigned N           = 9,
  parameter int unsigned MAXK        = 8,
  parameter int unsigned K_BITS      = $clog2(MAXK + 1),
  parameter int unsigned A_ADDR_BITS = $clog2(M * MAXK),
  parameter int unsigned B_ADDR_BITS = $clog2(MAXK * N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  output logic                   compute_finished,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  output logic                   mac_valid,
  output logic                   mac_first,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int unsigned I_BITS = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned J_BITS = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StTail,
    StOutput,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [I_BITS-1:0]      i_q, i_d;
  logic [J_BITS-1:0]      j_q, j_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic [K_BITS-1:0]      kq_q, kq_d;
  logic [A_ADDR_BITS-1:0] a_base_q, a_base_d;
  logic [A_ADDR_BITS-1:0] a_addr_q, a_addr_d;
  logic [B_ADDR_BITS-1:0] b_addr_q, b_addr_d;
  logic                   issue_q, issue_d;
  logic                   first_q, first_d;
  logic                   last_elem;
  logic                   k_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      kq_q     <= '0;
      a_base_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      issue_q  <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      kq_q     <= kq_d;
      a_base_q <= a_base_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      issue_q  <= issue_d;
      first_q  <= first_d;
    end
  end

  assign last_elem = (i_q == I_BITS'(M - 1)) && (j_q == J_BITS'(N - 1));
  assign k_last    = (k_q == kq_q - K_BITS'(1));

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    kq_d     = kq_q;
    a_base_d = a_base_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;

    case (state_q)
      StIdle: begin
        i_d      = '0;
        j_d      = '0;
        k_d      = '0;
        a_base_d = '0;
        if (matrices_loaded) begin
          kq_d = K;
          if (K == '0) begin
            state_d = StDone;
          end else begin
            state_d  = StIssue;
            a_addr_d = '0;
            b_addr_d = '0;
          end
        end
      end
      StIssue: begin
        // Addresses are registered, so the next term's address is prepared a cycle ahead.
        if (k_last) begin
          state_d = StTail;
        end else begin
          k_d      = k_q + K_BITS'(1);
          a_addr_d = a_addr_q + A_ADDR_BITS'(1);
          b_addr_d = b_addr_q + B_ADDR_BITS'(N);
        end
      end
      StTail: begin
        state_d = StOutput;
      end
      StOutput: begin
        if (out_ready) begin
          if (last_elem) begin
            state_d = StDone;
          end else begin
            k_d = '0;
            if (j_q == J_BITS'(N - 1)) begin
              j_d      = '0;
              i_d      = i_q + I_BITS'(1);
              a_base_d = a_base_q + A_ADDR_BITS'(kq_q);
            end else begin
              j_d = j_q + J_BITS'(1);
            end
            a_addr_d = a_base_d;
            b_addr_d = B_ADDR_BITS'(j_d);
            state_d  = StIssue;
          end
        end
      end
      StDone: begin
        // Wait for the memories to drop loaded so a stale job is never re-run.
        if (!matrices_loaded) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // One-cycle delay lines matching the memory read latency.
  assign issue_d = (state_q == StIssue);
  assign first_d = (k_q == '0);

  assign A_read_addr      = a_addr_q;
  assign B_read_addr      = b_addr_q;
  assign mac_valid        = issue_q;
  assign mac_first        = issue_q & first_q;
  assign out_valid        = (state_q == StOutput);
  assign out_last         = (state_q == StOutput) && last_elem;
  assign compute_finished = (state_q == StDone);

endmodule

// File: tb/tb_matmul_compute_ctrl.sv
// Scoreboard bench: memory + MAC models around the DUT, expected C computed from the plain
// matrix product and checked in order as results are accepted.
module tb_matmul_compute_ctrl;

  localparam int M    = 7;
  localparam int N    = 9;
  localparam int MAXK = 8;
  localparam int KB   = 4;
  localparam int AB   = 6;
  localparam int BB   = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          matrices_loaded = 1'b0;
  logic [KB-1:0] K = '0;
  logic          out_ready = 1'b1;
  logic          compute_finished;
  logic [AB-1:0] A_read_addr;
  logic [BB-1:0] B_read_addr;
  logic          mac_valid, mac_first, out_valid, out_last;

  always #5 clk = ~clk;

  matmul_compute_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .matrices_loaded  (matrices_loaded),
    .K                (K),
    .compute_finished (compute_finished),
    .A_read_addr      (A_read_addr),
    .B_read_addr      (B_read_addr),
    .mac_valid        (mac_valid),
    .mac_first        (mac_first),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last)
  );

  int unsigned a_mem [64];
  int unsigned b_mem [128];
  logic [31:0] a_dout, b_dout, acc;

  // Synchronous-read memories and the external MAC.
  always @(posedge clk) begin
    a_dout <= a_mem[A_read_addr];
    b_dout <= b_mem[B_read_addr];
    if (mac_valid) acc <= mac_first ? a_dout * b_dout : acc + a_dout * b_dout;
  end

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_q[$];
  bit          last_q[$];
  int          acc_count = 0;
  int          cur_k = 0;
  bit          rnd_ready = 0;
  int          stall_elem = -1;
  int          stall_left = 0;
  int unsigned max_a = 0, max_b = 0;
  int unsigned prev_a = 0, prev_b = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_acc;
  logic        stall_last;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_compute_finished"}, compute_finished, 0);
    check({tag, "_mac_valid"}, mac_valid, 0);
    check({tag, "_mac_first"}, mac_first, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_a_addr"}, A_read_addr, 0);
    check({tag, "_b_addr"}, B_read_addr, 0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (mac_valid) begin
        if (prev_a > max_a) max_a = prev_a;
        if (prev_b > max_b) max_b = prev_b;
        if (cur_k == 1) check("k1_mac_first", mac_first, 1);
      end
      prev_a = A_read_addr;
      prev_b = B_read_addr;
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", acc, stall_acc);
        check("stall_last", out_last, stall_last);
        check("stall_no_mac", mac_valid, 0);
      end
      stall_prev = out_valid && !out_ready;
      stall_acc  = acc;
      stall_last = out_last;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected no output", acc);
        end else begin
          int unsigned ev;
          bit el;
          ev = exp_q.pop_front();
          el = last_q.pop_front();
          check("result", acc, ev);
          check("out_last", out_last, el);
        end
        acc_count++;
      end
    end
  end

  // Consumer: optional random backpressure plus one directed stall.
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_left > 0 && out_valid && acc_count == stall_elem) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (rnd_ready) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end else begin
      out_ready = 1'b1;
    end
  end

  // Loads random matrices and queues the reference product in row-major order.
  task automatic start_job(input int k);
    for (int a = 0; a < 64; a++) a_mem[a] = $urandom_range(0, 255);
    for (int b = 0; b < 128; b++) b_mem[b] = $urandom_range(0, 255);
    if (k > 0) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < N; j++) begin
          int unsigned sum;
          sum = 0;
          for (int kk = 0; kk < k; kk++) sum += a_mem[i * k + kk] * b_mem[kk * N + j];
          exp_q.push_back(sum);
          last_q.push_back((i == M - 1) && (j == N - 1));
        end
      end
    end
    max_a = 0;
    max_b = 0;
    cur_k = k;
    acc_count = 0;
    K = KB'(k);
    matrices_loaded = 1'b1;
  endtask

  task automatic wait_done(input int budget, input bit disturb, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (disturb) begin
        if (n == 2) K = KB'($urandom);
        if (n == 20) matrices_loaded = 1'b0;
      end
    end while (!compute_finished && n < budget);
    if (!compute_finished) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: got no compute_finished after %0d cycles", n);
    end
  endtask

  task automatic finish_job(input int k);
    matrices_loaded = 1'b0;
    @(posedge clk);
    #1;
    check("cf_release", compute_finished, 0);
    check("queue_drained", exp_q.size(), 0);
    if (k > 0) begin
      check("max_a_addr", max_a, M * k - 1);
      check("max_b_addr", max_b, k * N - 1);
    end
  endtask

  initial begin
    int n;
    int k;
    int guard;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    start_job(8);
    wait_done(2000, 0, n);
    check("cycles_k8", n, M * N * 10 + 1);
    check("count_k8", acc_count, M * N);
    finish_job(8);

    stall_elem = 3;
    stall_left = 5;
    start_job(8);
    wait_done(2000, 0, n);
    check("cycles_stall", n, M * N * 10 + 1 + 5);
    finish_job(8);
    stall_elem = -1;

    start_job(1);
    wait_done(2000, 0, n);
    check("cycles_k1", n, M * N * 3 + 1);
    finish_job(1);

    start_job(0);
    wait_done(50, 0, n);
    check("cycles_k0", n, 1);
    check("count_k0", acc_count, 0);
    finish_job(0);

    start_job(3);
    wait_done(2000, 0, n);
    check("cycles_k3", n, M * N * 5 + 1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("cf_hold", compute_finished, 1);
      check("no_restart", mac_valid | out_valid, 0);
    end
    finish_job(3);
    start_job(5);
    wait_done(2000, 0, n);
    check("cycles_k5", n, M * N * 7 + 1);
    finish_job(5);

    rnd_ready = 1;
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, MAXK);
      start_job(k);
      wait_done(20000, r == 1, n);
      check("cycles_min", n >= M * N * (k + 2) + 1, 1);
      finish_job(k);
    end
    rnd_ready = 0;

    start_job(4);
    guard = 0;
    while (!(acc_count == 4 && mac_valid) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reach_elem4", acc_count == 4 && mac_valid, 1);
    reset = 1'b1;
    matrices_loaded = 1'b0;
    @(posedge clk);
    #1;
    check_idle("midreset");
    reset = 1'b0;
    exp_q.delete();
    last_q.delete();
    start_job(2);
    wait_done(2000, 0, n);
    check("cycles_after_reset", n, M * N * 4 + 1);
    finish_job(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
